// File: rtl/speed_table.sv
// speed_table: per-object speed table with aging, NCH read channels and a
// background max-speed scanner. After reset an INIT sweep zeroes every entry
// (one per cycle) before writes are accepted.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_wr_valid/o_wr_ready    write handshake; i_wr_addr, i_wr_speed payload
//   i_clr, i_clr_addr        invalidate one entry
//   i_tick                   age every valid entry by one (saturating)
//   i_sel, i_sel_addr        per-channel object-ID load strobe / ID
//   o_speed/o_id/o_valid/o_stale   per-channel view of the latched ID
//   o_max_speed/o_max_id/o_max_valid  fastest live (valid, not stale) entry
module speed_table #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 6,
  parameter int unsigned NCH   = 2,
  parameter int unsigned AGE_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  input  logic [DEPTH-1:0]       i_wr_addr,
  input  logic [WIDTH-1:0]       i_wr_speed,
  input  logic                   i_clr,
  input  logic [DEPTH-1:0]       i_clr_addr,
  input  logic                   i_tick,
  input  logic [NCH-1:0]         i_sel,
  input  logic [NCH*DEPTH-1:0]   i_sel_addr,
  output logic [NCH*WIDTH-1:0]   o_speed,
  output logic [NCH*DEPTH-1:0]   o_id,
  output logic [NCH-1:0]         o_valid,
  output logic [NCH-1:0]         o_stale,
  output logic [WIDTH-1:0]       o_max_speed,
  output logic [DEPTH-1:0]       o_max_id,
  output logic                   o_max_valid
);

  localparam int unsigned N = 2**DEPTH;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [DEPTH-1:0] LAST_IDX = DEPTH'(N - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] sweep_q;

  logic [WIDTH-1:0] speed_q [N];
  logic [AGE_W-1:0] age_q   [N];
  logic [N-1:0]     valid_q;

  logic [DEPTH-1:0] chan_id_q [NCH];

  logic [DEPTH-1:0] scan_idx_q;
  logic [WIDTH-1:0] run_speed_q, pub_speed_q;
  logic [DEPTH-1:0] run_id_q,    pub_id_q;
  logic             run_valid_q, pub_valid_q;

  logic run, wr_fire, clr_fire, tick_fire;

  assign run       = (state_q == S_RUN);
  assign wr_fire   = i_wr_valid && run;
  // A write to the same address in the same cycle overrides the clear.
  assign clr_fire  = i_clr && run && !(wr_fire && (i_wr_addr == i_clr_addr));
  assign tick_fire = i_tick && run;

  assign o_wr_ready = run;

  // State register and INIT sweep counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      if (!run) sweep_q <= sweep_q + DEPTH'(1);
    end
  end

  // Next-state logic: leave INIT after the last entry has been swept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (sweep_q == LAST_IDX) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
    endcase
  end

  // Entry speed/age storage; INIT sweep, writes and aging.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!run && (sweep_q == DEPTH'(i))) begin
          speed_q[i] <= '0;
          age_q[i]   <= '0;
        end else if (wr_fire && (i_wr_addr == DEPTH'(i))) begin
          speed_q[i] <= i_wr_speed;
          age_q[i]   <= '0;
        end else if (tick_fire && valid_q[i] && (age_q[i] != AGE_MAX)) begin
          age_q[i] <= age_q[i] + AGE_W'(1);
        end
      end
    end
  end

  // Valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (wr_fire && (i_wr_addr == DEPTH'(i)))        valid_q[i] <= 1'b1;
        else if (clr_fire && (i_clr_addr == DEPTH'(i))) valid_q[i] <= 1'b0;
      end
    end
  end

  // Per-channel latched IDs and combinational read-out.
  for (genvar k = 0; k < NCH; k++) begin : g_chan
    always_ff @(posedge clk) begin
      if (rst)                  chan_id_q[k] <= '0;
      else if (run && i_sel[k]) chan_id_q[k] <= i_sel_addr[k*DEPTH +: DEPTH];
    end

    assign o_id[k*DEPTH +: DEPTH]    = chan_id_q[k];
    assign o_valid[k]                = valid_q[chan_id_q[k]];
    assign o_stale[k]                = valid_q[chan_id_q[k]] && (age_q[chan_id_q[k]] == AGE_MAX);
    assign o_speed[k*WIDTH +: WIDTH] = valid_q[chan_id_q[k]] ? speed_q[chan_id_q[k]] : '0;
  end

  // Max scanner: strictly-greater replacement keeps the lowest index on ties.
  logic             cur_take;
  logic [WIDTH-1:0] nxt_speed;
  logic [DEPTH-1:0] nxt_id;
  logic             nxt_valid;

  always_comb begin
    cur_take  = valid_q[scan_idx_q] && (age_q[scan_idx_q] != AGE_MAX) &&
                (!run_valid_q || (speed_q[scan_idx_q] > run_speed_q));
    nxt_speed = run_speed_q;
    nxt_id    = run_id_q;
    nxt_valid = run_valid_q;
    if (cur_take) begin
      nxt_speed = speed_q[scan_idx_q];
      nxt_id    = scan_idx_q;
      nxt_valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_idx_q  <= '0;
      run_speed_q <= '0;
      run_id_q    <= '0;
      run_valid_q <= 1'b0;
      pub_speed_q <= '0;
      pub_id_q    <= '0;
      pub_valid_q <= 1'b0;
    end else if (run) begin
      scan_idx_q <= scan_idx_q + DEPTH'(1);
      if (scan_idx_q == LAST_IDX) begin
        pub_speed_q <= nxt_valid ? nxt_speed : '0;
        pub_id_q    <= nxt_valid ? nxt_id : '0;
        pub_valid_q <= nxt_valid;
        run_speed_q <= '0;
        run_id_q    <= '0;
        run_valid_q <= 1'b0;
      end else begin
        run_speed_q <= nxt_speed;
        run_id_q    <= nxt_id;
        run_valid_q <= nxt_valid;
      end
    end
  end

  assign o_max_speed = pub_speed_q;
  assign o_max_id    = pub_id_q;
  assign o_max_valid = pub_valid_q;

endmodule

// File: tb/tb_speed_table.sv
// Directed bench for speed_table with default parameters (8-bit speed,
// 64 entries, 2 channels, 4-bit age).
module tb_speed_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_wr_valid;
  logic        o_wr_ready;
  logic [5:0]  i_wr_addr;
  logic [7:0]  i_wr_speed;
  logic        i_clr;
  logic [5:0]  i_clr_addr;
  logic        i_tick;
  logic [1:0]  i_sel;
  logic [11:0] i_sel_addr;
  logic [15:0] o_speed;
  logic [11:0] o_id;
  logic [1:0]  o_valid;
  logic [1:0]  o_stale;
  logic [7:0]  o_max_speed;
  logic [5:0]  o_max_id;
  logic        o_max_valid;

  speed_table dut (
    .clk(clk), .rst(rst),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_addr(i_wr_addr), .i_wr_speed(i_wr_speed),
    .i_clr(i_clr), .i_clr_addr(i_clr_addr), .i_tick(i_tick),
    .i_sel(i_sel), .i_sel_addr(i_sel_addr),
    .o_speed(o_speed), .o_id(o_id), .o_valid(o_valid), .o_stale(o_stale),
    .o_max_speed(o_max_speed), .o_max_id(o_max_id), .o_max_valid(o_max_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       wr_v;
    logic [5:0] wr_a;
    logic [7:0] wr_s;
    logic       clr;
    logic [5:0] clr_a;
    logic       tick;
    logic [1:0] sel;
    logic [5:0] sa0;
    logic [5:0] sa1;
    logic [1:0] e_valid;
    logic [1:0] e_stale;
    logic [7:0] e_sp0;
    logic [7:0] e_sp1;
    logic [5:0] e_id0;
    logic [5:0] e_id1;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_wr_valid = 1'b0; i_wr_addr = '0; i_wr_speed = '0;
    i_clr = 1'b0; i_clr_addr = '0; i_tick = 1'b0;
    i_sel = '0; i_sel_addr = '0;
  endtask

  // One cycle of stimulus, then inputs return to idle.
  task automatic cyc(input logic wv, input logic [5:0] wa, input logic [7:0] ws,
                     input logic c, input logic [5:0] ca, input logic t,
                     input logic [1:0] s, input logic [5:0] s0, input logic [5:0] s1);
    i_wr_valid = wv; i_wr_addr = wa; i_wr_speed = ws;
    i_clr = c; i_clr_addr = ca; i_tick = t;
    i_sel = s; i_sel_addr = {s1, s0};
    step();
    idle_inputs();
  endtask

  function automatic logic outs_zero();
    return (o_speed == '0) && (o_id == '0) && (o_valid == '0) && (o_stale == '0) &&
           (o_max_speed == '0) && (o_max_id == '0) && (o_max_valid == 1'b0);
  endfunction

  // Counts cycles with o_wr_ready low (bounded) and whether all outputs stayed 0.
  task automatic count_init(output int cnt, output logic all_zero);
    cnt = 0;
    all_zero = 1'b1;
    while (!o_wr_ready && cnt < 200) begin
      if (!outs_zero()) all_zero = 1'b0;
      cnt++;
      step();
    end
  endtask

  task automatic check_max(input string tag, input logic [7:0] sp, input logic [5:0] id, input logic v);
    check({tag, "_max_speed"}, 32'(o_max_speed), 32'(sp));
    check({tag, "_max_id"},    32'(o_max_id),    32'(id));
    check({tag, "_max_valid"}, 32'(o_max_valid), 32'(v));
  endtask

  initial begin
    int   cnt;
    logic zflag;

    vecs[0] = '{1'b0, 6'd0, 8'd0,   1'b0, 6'd0, 1'b0, 2'b11, 6'd5, 6'd5, 2'b00, 2'b00, 8'd0,  8'd0,  6'd5, 6'd5};
    vecs[1] = '{1'b1, 6'd5, 8'd80,  1'b0, 6'd0, 1'b0, 2'b00, 6'd0, 6'd0, 2'b11, 2'b00, 8'd80, 8'd80, 6'd5, 6'd5};
    vecs[2] = '{1'b1, 6'd9, 8'd40,  1'b0, 6'd0, 1'b0, 2'b10, 6'd0, 6'd9, 2'b11, 2'b00, 8'd80, 8'd40, 6'd5, 6'd9};
    vecs[3] = '{1'b1, 6'd3, 8'd50,  1'b1, 6'd3, 1'b0, 2'b01, 6'd3, 6'd0, 2'b11, 2'b00, 8'd50, 8'd40, 6'd3, 6'd9};
    vecs[4] = '{1'b0, 6'd0, 8'd0,   1'b1, 6'd3, 1'b0, 2'b00, 6'd0, 6'd0, 2'b10, 2'b00, 8'd0,  8'd40, 6'd3, 6'd9};
    vecs[5] = '{1'b1, 6'd5, 8'd81,  1'b1, 6'd9, 1'b0, 2'b01, 6'd5, 6'd0, 2'b01, 2'b00, 8'd81, 8'd0,  6'd5, 6'd9};
    vecs[6] = '{1'b1, 6'd9, 8'd40,  1'b0, 6'd0, 1'b0, 2'b00, 6'd0, 6'd0, 2'b11, 2'b00, 8'd81, 8'd40, 6'd5, 6'd9};

    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("reset_outputs_zero", 32'(outs_zero()), 32'd1);
    check("reset_wr_ready", 32'(o_wr_ready), 32'd0);

    // Write and select attempts during INIT must be ignored.
    i_wr_valid = 1'b1; i_wr_addr = 6'd5; i_wr_speed = 8'd77;
    i_sel = 2'b11; i_sel_addr = {6'd5, 6'd5};
    count_init(cnt, zflag);
    idle_inputs();
    check("init_cycles", 32'(cnt), 32'd64);
    check("init_outputs_zero", 32'(zflag), 32'd1);
    check("run_wr_ready", 32'(o_wr_ready), 32'd1);
    check("run_id_after_init", 32'(o_id), 32'd0);

    for (int v = 0; v < 7; v++) begin
      cyc(vecs[v].wr_v, vecs[v].wr_a, vecs[v].wr_s, vecs[v].clr, vecs[v].clr_a,
          vecs[v].tick, vecs[v].sel, vecs[v].sa0, vecs[v].sa1);
      check($sformatf("v%0d_valid", v), 32'(o_valid), 32'(vecs[v].e_valid));
      check($sformatf("v%0d_stale", v), 32'(o_stale), 32'(vecs[v].e_stale));
      check($sformatf("v%0d_speed0", v), 32'(o_speed[7:0]), 32'(vecs[v].e_sp0));
      check($sformatf("v%0d_speed1", v), 32'(o_speed[15:8]), 32'(vecs[v].e_sp1));
      check($sformatf("v%0d_id0", v), 32'(o_id[5:0]), 32'(vecs[v].e_id0));
      check($sformatf("v%0d_id1", v), 32'(o_id[11:6]), 32'(vecs[v].e_id1));
    end

    // Aging: IDs 5 and 9 both age 0 now.
    for (int t = 0; t < 14; t++) cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("age14_stale", 32'(o_stale), 32'd0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("age15_stale", 32'(o_stale), 32'd3);
    check("age15_valid", 32'(o_valid), 32'd3);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("age_saturate_stale", 32'(o_stale), 32'd3);
    cyc(1, 9, 45, 0, 0, 1, 0, 0, 0);
    check("rewrite_tick_stale", 32'(o_stale), 32'd1);
    check("rewrite_tick_speed1", 32'(o_speed[15:8]), 32'd45);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
    check("rewrite_then_tick_stale", 32'(o_stale), 32'd1);

    // Stale ID 5 (speed 81) is excluded from the max.
    repeat (130) step();
    check_max("stale_excl", 8'd45, 6'd9, 1'b1);

    cyc(0, 0, 0, 1, 5, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 9, 0, 0, 0, 0);
    cyc(1, 2, 100, 0, 0, 0, 0, 0, 0);
    cyc(1, 7, 100, 0, 0, 0, 0, 0, 0);
    cyc(1, 4, 60, 0, 0, 0, 0, 0, 0);
    repeat (130) step();
    check_max("tie", 8'd100, 6'd2, 1'b1);

    cyc(0, 0, 0, 1, 2, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 4, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 7, 0, 0, 0, 0);
    repeat (130) step();
    check_max("empty", 8'd0, 6'd0, 1'b0);

    // Reset in the middle of RUN.
    cyc(1, 6, 33, 0, 0, 0, 2'b11, 6'd6, 6'd6);
    check("pre_rst_speed0", 32'(o_speed[7:0]), 32'd33);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrun_rst_zero", 32'(outs_zero()), 32'd1);
    check("midrun_rst_ready", 32'(o_wr_ready), 32'd0);
    count_init(cnt, zflag);
    check("reinit_cycles", 32'(cnt), 32'd64);
    check("reinit_outputs_zero", 32'(zflag), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 2'b11, 6'd6, 6'd2);
    check("post_rst_valid", 32'(o_valid), 32'd0);
    check("post_rst_speed", 32'(o_speed), 32'd0);
    check("post_rst_id", 32'(o_id), 32'({6'd2, 6'd6}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
